// File: rtl/boot_image_loader.sv
// Boot image loader: parses a length-prefixed firmware byte stream, writes the
// payload into XRAM starting at BASE_ADDR and verifies the trailing mod-256
// checksum. Integrator must keep BASE_ADDR + MAX_LEN <= 2**ADDR_W.
module boot_image_loader #(
  parameter int unsigned       ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(16'h0000),
  parameter logic [15:0]       MAX_LEN   = 16'h1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned LEN_W  = 16;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WR,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_e;

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   sum_q, sum_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;

  logic                consume_c;
  logic                wr_ack_c;
  logic [LEN_W-1:0]    len_full_c;
  logic [LEN_W-1:0]    cnt_inc_c;

  // Handshake qualifiers and the length/count values used by the FSM.
  assign consume_c  = in_valid & in_ready_q;
  assign wr_ack_c   = we_q & mem_ready;
  assign len_full_c = {len_q[LEN_W-1:8], in_data};
  assign cnt_inc_c  = cnt_q + LEN_W'(1);

  // Next-state and next-output logic; abort overrides every other condition.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    we_d    = we_q;
    done_d  = done_q;
    error_d = error_q;

    if (abort) begin
      state_d = S_IDLE;
      we_d    = 1'b0;
      done_d  = 1'b0;
      error_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_d = S_LEN_HI;
            done_d  = 1'b0;
            error_d = 1'b0;
            sum_d   = '0;
            cnt_d   = '0;
          end
        end
        S_LEN_HI: begin
          if (consume_c) begin
            len_d[LEN_W-1:8] = in_data;
            state_d          = S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (consume_c) begin
            len_d = len_full_c;
            if (len_full_c > MAX_LEN) begin
              state_d = S_ERR;
              error_d = 1'b1;
            end else if (len_full_c == '0) begin
              state_d = S_CSUM;
            end else begin
              state_d = S_DATA;
            end
          end
        end
        S_DATA: begin
          if (consume_c) begin
            wdata_d = in_data;
            addr_d  = BASE_ADDR + ADDR_W'(cnt_q);
            sum_d   = sum_q + in_data;
            we_d    = 1'b1;
            state_d = S_WR;
          end
        end
        S_WR: begin
          if (wr_ack_c) begin
            we_d    = 1'b0;
            cnt_d   = cnt_inc_c;
            state_d = (cnt_inc_c == len_q) ? S_CSUM : S_DATA;
          end
        end
        S_CSUM: begin
          if (consume_c) begin
            if (in_data == sum_q) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_ERR;
              error_d = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    in_ready_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                 (state_d == S_DATA)   || (state_d == S_CSUM);
    busy_d     = !((state_d == S_IDLE) || (state_d == S_DONE) ||
                   (state_d == S_ERR));
  end

  // State and registered-output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      sum_q      <= '0;
      wdata_q    <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      wdata_q    <= wdata_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      done_q     <= done_d;
      error_q    <= error_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_boot_image_loader.sv
// Bench for boot_image_loader: table of fixed images, hand-written multi-cycle
// corner cases, and randomized images checked against a transaction-level model.
module tb_boot_image_loader;

  localparam int unsigned ADDR_W   = 16;
  localparam logic [15:0] BASE     = 16'h0000;
  localparam logic [15:0] MAXL     = 16'h1000;
  localparam logic [15:0] ADDR_MAX = BASE + MAXL - 16'd1;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  typedef struct {
    logic [63:0] bytes;
    int          nb;
    bit          e_done;
    bit          e_err;
    int          e_wr;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_ready = 1'b0;
  logic              busy;
  logic              done;
  logic              error;

  int   vectors = 0;
  int   miscompares = 0;

  bit   rdy_rand = 1'b0;
  bit   rdy_force = 1'b1;
  bit   gap_rand = 1'b0;

  logic [7:0] img_q [$];
  wr_t        wr_log [$];
  wr_t        exp_q [$];
  bit         e_done, e_err;
  int         e_nb;
  bit         got_done, got_err;
  int         got_nwr;

  vec_t tbl [7];

  boot_image_loader #(
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE),
    .MAX_LEN  (MAXL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ready(mem_ready),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory side: drive mem_ready shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    mem_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
  end

  // Write monitor: a write completes on the coming edge when we & ready & !abort.
  always @(negedge clk) begin
    if (rst_n && mem_we && mem_ready && !abort) begin
      wr_log.push_back('{a: mem_addr, d: mem_wdata});
      check("addr_range", 32'(mem_addr <= ADDR_MAX), 32'd1);
    end
  end

  // Expected result of an image, straight from the format rules.
  task automatic model_run();
    int len;
    int s;
    exp_q.delete();
    len = int'({img_q[0], img_q[1]});
    if (len > int'(MAXL)) begin
      e_done = 1'b0;
      e_err  = 1'b1;
      e_nb   = 2;
    end else begin
      s = 0;
      for (int i = 0; i < len; i++) begin
        exp_q.push_back('{a: 16'(int'(BASE) + i), d: img_q[2 + i]});
        s = (s + int'(img_q[2 + i])) % 256;
      end
      e_done = (img_q[2 + len] == 8'(s));
      e_err  = !e_done;
      e_nb   = len + 3;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Present one byte and hold it until the loader takes it; ends at posedge+1.
  task automatic send_byte(input logic [7:0] b);
    int n;
    int k;
    n = 0;
    k = gap_rand ? int'($urandom_range(0, 2)) : 0;
    repeat (k) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // The terminal flag must appear at the first negedge after the last byte.
  task automatic wait_terminal(input string tag);
    int lat;
    lat = 0;
    @(negedge clk);
    while (!(done || error) && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("%s_term_latency", tag), 32'(lat), 32'd0);
  endtask

  task automatic run_load(input string tag);
    int n;
    wr_log.delete();
    model_run();
    pulse_start();
    for (int i = 0; i < e_nb; i++) send_byte(img_q[i]);
    wait_terminal(tag);
    got_done = done;
    got_err  = error;
    got_nwr  = wr_log.size();
    check($sformatf("%s_done", tag), 32'(done), 32'(e_done));
    check($sformatf("%s_error", tag), 32'(error), 32'(e_err));
    check($sformatf("%s_busy", tag), 32'(busy), 32'd0);
    check($sformatf("%s_in_ready", tag), 32'(in_ready), 32'd0);
    check($sformatf("%s_nwr", tag), 32'(wr_log.size()), 32'(exp_q.size()));
    n = (wr_log.size() < exp_q.size()) ? wr_log.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (wr_log[i] !== exp_q[i])
        check($sformatf("%s_wr%0d", tag, i), 32'(wr_log[i]), 32'(exp_q[i]));
      else
        vectors++;
    @(posedge clk); #1;
  endtask

  task automatic load_vec(input int idx);
    logic [63:0] bb;
    bb = tbl[idx].bytes;
    img_q.delete();
    for (int i = 0; i < tbl[idx].nb; i++) img_q.push_back(bb[63 - 8 * i -: 8]);
  endtask

  task automatic check_idle_outputs(input string tag);
    check($sformatf("%s_mem_we", tag), 32'(mem_we), 32'd0);
    check($sformatf("%s_mem_addr", tag), 32'(mem_addr), 32'd0);
    check($sformatf("%s_mem_wdata", tag), 32'(mem_wdata), 32'd0);
    check($sformatf("%s_in_ready", tag), 32'(in_ready), 32'd0);
    check($sformatf("%s_busy", tag), 32'(busy), 32'd0);
    check($sformatf("%s_done", tag), 32'(done), 32'd0);
    check($sformatf("%s_error", tag), 32'(error), 32'd0);
  endtask

  initial begin
    #900000;
    miscompares++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    int len;
    int s;
    logic [7:0] c;

    tbl[0] = '{64'h0003_1122_3366_0000, 6, 1'b1, 1'b0, 3};  // nominal
    tbl[1] = '{64'h0003_1122_3367_0000, 6, 1'b0, 1'b1, 3};  // bad checksum
    tbl[2] = '{64'h0000_0000_0000_0000, 3, 1'b1, 1'b0, 0};  // zero length
    tbl[3] = '{64'h1001_0000_0000_0000, 2, 1'b0, 1'b1, 0};  // MAX_LEN+1
    tbl[4] = '{64'h0002_FF02_0100_0000, 5, 1'b1, 1'b0, 2};  // sum wraps
    tbl[5] = '{64'hFFFF_0000_0000_0000, 2, 1'b0, 1'b1, 0};  // largest length
    tbl[6] = '{64'h0001_807F_0000_0000, 4, 1'b0, 1'b1, 1};  // single byte, bad

    // Reset state
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fixed images, memory always ready, stream always valid
    for (int v = 0; v < 7; v++) begin
      load_vec(v);
      run_load($sformatf("tbl%0d", v));
      check($sformatf("tbl%0d_vs_done", v), 32'(got_done), 32'(tbl[v].e_done));
      check($sformatf("tbl%0d_vs_error", v), 32'(got_err), 32'(tbl[v].e_err));
      check($sformatf("tbl%0d_vs_nwr", v), 32'(got_nwr), 32'(tbl[v].e_wr));
      // A following byte must not be taken while terminal
      in_valid = 1'b1;
      in_data  = 8'h5A;
      @(negedge clk);
      check($sformatf("tbl%0d_post_in_ready", v), 32'(in_ready), 32'd0);
      check($sformatf("tbl%0d_post_flags", v), 32'({done, error}),
            32'({tbl[v].e_done, tbl[v].e_err}));
      @(posedge clk); #1;
      in_valid = 1'b0;
    end

    // Backpressure on the first write; a start during WR is ignored
    img_q = '{8'h00, 8'h02, 8'hAA, 8'h55, 8'hFF};
    wr_log.delete();
    rdy_force = 1'b0;
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'hAA);
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp%0d_mem_we", i), 32'(mem_we), 32'd1);
      check($sformatf("bp%0d_mem_addr", i), 32'(mem_addr), 32'(BASE));
      check($sformatf("bp%0d_mem_wdata", i), 32'(mem_wdata), 32'hAA);
      check($sformatf("bp%0d_in_ready", i), 32'(in_ready), 32'd0);
      check($sformatf("bp%0d_busy", i), 32'(busy), 32'd1);
      @(posedge clk); #1;
      start = 1'b0;
    end
    rdy_force = 1'b1;
    send_byte(8'h55);
    send_byte(8'hFF);
    wait_terminal("bp");
    check("bp_done", 32'(done), 32'd1);
    check("bp_error", 32'(error), 32'd0);
    check("bp_nwr", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() == 2) begin
      check("bp_wr0", 32'(wr_log[0]), 32'({16'(BASE), 8'hAA}));
      check("bp_wr1", 32'(wr_log[1]), 32'({16'(BASE + 16'd1), 8'h55}));
    end
    @(posedge clk); #1;

    // Abort together with mem_ready while a write is pending
    wr_log.delete();
    rdy_force = 1'b0;
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h03);
    send_byte(8'h11);
    @(negedge clk);
    check("ab_pre_mem_we", 32'(mem_we), 32'd1);
    @(posedge clk); #1;
    abort = 1'b1;
    rdy_force = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    rdy_force = 1'b0;
    @(negedge clk);
    check("ab_mem_we", 32'(mem_we), 32'd0);
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_in_ready", 32'(in_ready), 32'd0);
    check("ab_flags", 32'({done, error}), 32'd0);
    check("ab_nwr", 32'(wr_log.size()), 32'd0);
    @(posedge clk); #1;
    // start and abort in the same cycle: abort wins
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("ab_start_busy", 32'(busy), 32'd0);
    check("ab_start_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rdy_force = 1'b1;
    load_vec(0);
    run_load("ab_reload");

    // Asynchronous reset while a write is pending
    rdy_force = 1'b0;
    wr_log.delete();
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h03);
    send_byte(8'h11);
    @(negedge clk);
    check("rs_pre_mem_wdata", 32'(mem_wdata), 32'h11);
    check("rs_pre_mem_we", 32'(mem_we), 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rs");
    @(negedge clk);
    rst_n = 1'b1;
    rdy_force = 1'b1;
    @(posedge clk); #1;
    load_vec(0);
    run_load("rs_reload");

    // Randomized images, random stream gaps and memory stalls
    gap_rand = 1'b1;
    rdy_rand = 1'b1;
    for (int t = 0; t < 25; t++) begin
      img_q.delete();
      if ($urandom_range(0, 7) == 0) begin
        len = int'(MAXL) + 1 + int'($urandom_range(0, 200));
        img_q.push_back(8'(len >> 8));
        img_q.push_back(8'(len));
      end else begin
        len = int'($urandom_range(0, 24));
        img_q.push_back(8'(len >> 8));
        img_q.push_back(8'(len));
        s = 0;
        for (int i = 0; i < len; i++) begin
          c = 8'($urandom_range(0, 255));
          img_q.push_back(c);
          s = s + int'(c);
        end
        c = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'(s);
        img_q.push_back(c);
      end
      run_load($sformatf("rnd%0d", t));
    end

    // Exactly MAX_LEN payload bytes: last address is BASE+MAX_LEN-1
    gap_rand = 1'b0;
    rdy_rand = 1'b0;
    rdy_force = 1'b1;
    img_q.delete();
    img_q.push_back(MAXL[15:8]);
    img_q.push_back(MAXL[7:0]);
    s = 0;
    for (int i = 0; i < int'(MAXL); i++) begin
      c = 8'($urandom_range(0, 255));
      img_q.push_back(c);
      s = s + int'(c);
    end
    img_q.push_back(8'(s));
    run_load("maxlen");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
